// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: accepts moves via valid/ready, enforces turns, declares win/draw/forfeit.
// Optional per-turn timeout forfeit when MOVE_TIMEOUT_EN is defined.
module ttt_game_ctrl #(
    parameter bit FIRST_PLAYER   = 1'b0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       move_valid,
    input  logic       move_player,
    input  logic [8:0] move_pos,
    output logic       move_ready,
    output logic       illegal,
    output logic [8:0] ain,
    output logic [8:0] bin,
    output logic       turn,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [7:0] win_line,
    output logic       forfeit
);

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_CHECK, S_DONE} state_t;

    state_t     state, state_nxt;
    logic       pos_onehot;
    logic       accept;
    logic       timeout_hit;
    logic [8:0] mover_board;
    logic [7:0] lines;
    logic [7:0] win_first;
    logic       has_win;
    logic       is_draw;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    assign pos_onehot = (move_pos != 9'd0) && ((move_pos & (move_pos - 9'd1)) == 9'd0);
    assign accept     = (state == S_TURN) && move_valid && (move_player == turn) &&
                        pos_onehot && ((move_pos & (ain | bin)) == 9'd0);

    // turn has not toggled yet in CHECK, so it still names the player who just moved
    assign mover_board = turn ? bin : ain;

    always_comb begin
        lines    = 8'd0;
        lines[0] = (mover_board & 9'b111_000_000) == 9'b111_000_000;
        lines[1] = (mover_board & 9'b000_111_000) == 9'b000_111_000;
        lines[2] = (mover_board & 9'b000_000_111) == 9'b000_000_111;
        lines[3] = (mover_board & 9'b100_100_100) == 9'b100_100_100;
        lines[4] = (mover_board & 9'b010_010_010) == 9'b010_010_010;
        lines[5] = (mover_board & 9'b001_001_001) == 9'b001_001_001;
        lines[6] = (mover_board & 9'b100_010_001) == 9'b100_010_001;
        lines[7] = (mover_board & 9'b001_010_100) == 9'b001_010_100;
    end

    // isolate lowest set bit so a double line still reports one-hot
    assign win_first = lines & (~lines + 8'd1);
    assign has_win   = |lines;
    assign is_draw   = (move_count == 4'd9);

`ifdef MOVE_TIMEOUT_EN
    logic [15:0] turn_cnt;
    logic        forfeit_q;

    assign timeout_hit = (state == S_TURN) && !accept && (turn_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign forfeit     = forfeit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_cnt  <= 16'd0;
            forfeit_q <= 1'b0;
        end else begin
            turn_cnt <= (state == S_TURN) ? turn_cnt + 16'd1 : 16'd0;
            if (((state == S_IDLE) || (state == S_DONE)) && start)
                forfeit_q <= 1'b0;
            else if (timeout_hit)
                forfeit_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign forfeit     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_TURN;
            S_TURN: begin
                if (accept)           state_nxt = S_CHECK;
                else if (timeout_hit) state_nxt = S_DONE;
            end
            S_CHECK: state_nxt = (has_win || is_draw) ? S_DONE : S_TURN;
            S_DONE:  if (start) state_nxt = S_TURN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        move_ready = (state == S_TURN);
        game_over  = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ain        <= 9'd0;
            bin        <= 9'd0;
            turn       <= FIRST_PLAYER;
            move_count <= 4'd0;
            winner     <= 2'b00;
            win_line   <= 8'd0;
            illegal    <= 1'b0;
        end else begin
            illegal <= (state == S_TURN) && move_valid && !accept;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ain        <= 9'd0;
                        bin        <= 9'd0;
                        turn       <= FIRST_PLAYER;
                        move_count <= 4'd0;
                        winner     <= 2'b00;
                        win_line   <= 8'd0;
                    end
                end
                S_TURN: begin
                    if (accept) begin
                        if (turn) bin <= bin | move_pos;
                        else      ain <= ain | move_pos;
                        move_count <= move_count + 4'd1;
                    end else if (timeout_hit) begin
                        winner   <= turn ? 2'b01 : 2'b10;
                        win_line <= 8'd0;
                    end
                end
                S_CHECK: begin
                    if (has_win) begin
                        winner   <= turn ? 2'b10 : 2'b01;
                        win_line <= win_first;
                    end else if (is_draw) begin
                        winner   <= 2'b11;
                        win_line <= 8'd0;
                    end else begin
                        turn <= ~turn;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl; timeout scenario runs only when MOVE_TIMEOUT_EN is defined.
module tb_ttt_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       move_valid;
    logic       move_player;
    logic [8:0] move_pos;
    logic       move_ready;
    logic       illegal;
    logic [8:0] ain;
    logic [8:0] bin;
    logic       turn;
    logic [3:0] move_count;
    logic       game_over;
    logic [1:0] winner;
    logic [7:0] win_line;
    logic       forfeit;

    int n_chk  = 0;
    int n_fail = 0;

    ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
        .move_player(move_player), .move_pos(move_pos), .move_ready(move_ready),
        .illegal(illegal), .ain(ain), .bin(bin), .turn(turn), .move_count(move_count),
        .game_over(game_over), .winner(winner), .win_line(win_line), .forfeit(forfeit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // present a move for one edge, then let the CHECK cycle complete
    task automatic play(input logic p, input logic [8:0] pos);
        move_valid = 1'b1; move_player = p; move_pos = pos;
        tick();
        move_valid = 1'b0; move_pos = 9'd0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; move_player = 1'b0; move_pos = 9'd0;
        #12;
        n_chk++; if (ain !== 9'd0 || bin !== 9'd0) begin n_fail++; $display("FAIL rst_boards ain=%h bin=%h exp 0/0", ain, bin); end
        n_chk++; if (move_ready !== 1'b0 || game_over !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL rst_flags ready=%b over=%b illegal=%b exp 000", move_ready, game_over, illegal); end
        n_chk++; if (turn !== 1'b0 || move_count !== 4'd0 || winner !== 2'd0 || win_line !== 8'd0 || forfeit !== 1'b0) begin n_fail++; $display("FAIL rst_state turn=%b cnt=%0d win=%b line=%h forf=%b exp all 0", turn, move_count, winner, win_line, forfeit); end
        rst_n = 1'b1;
        move_valid = 1'b1; move_player = 1'b0; move_pos = 9'h001;
        tick();
        n_chk++; if (move_ready !== 1'b0 || illegal !== 1'b0 || ain !== 9'd0) begin n_fail++; $display("FAIL idle_ignore ready=%b illegal=%b ain=%h exp 0 0 000", move_ready, illegal, ain); end
        move_valid = 1'b0; move_pos = 9'd0;
    endtask

    task automatic test_row_win();
        start_game();
        n_chk++; if (move_ready !== 1'b1 || turn !== 1'b0 || move_count !== 4'd0) begin n_fail++; $display("FAIL start_turn ready=%b turn=%b cnt=%0d exp 1 0 0", move_ready, turn, move_count); end
        play(1'b0, 9'h100);
        n_chk++; if (turn !== 1'b1 || ain !== 9'h100) begin n_fail++; $display("FAIL first_move turn=%b ain=%h exp 1 100", turn, ain); end
        play(1'b1, 9'h010);
        play(1'b0, 9'h080);
        play(1'b1, 9'h001);
        n_chk++; if (game_over !== 1'b0 || turn !== 1'b0 || move_count !== 4'd4) begin n_fail++; $display("FAIL mid_game over=%b turn=%b cnt=%0d exp 0 0 4", game_over, turn, move_count); end
        move_valid = 1'b1; move_player = 1'b0; move_pos = 9'h040;
        tick();
        move_valid = 1'b0; move_pos = 9'd0;
        n_chk++; if (move_ready !== 1'b0 || game_over !== 1'b0 || winner !== 2'b00) begin n_fail++; $display("FAIL check_cycle ready=%b over=%b win=%b exp 0 0 00", move_ready, game_over, winner); end
        tick();
        n_chk++; if (game_over !== 1'b1 || winner !== 2'b01 || win_line !== 8'h01) begin n_fail++; $display("FAIL row_win over=%b win=%b line=%h exp 1 01 01", game_over, winner, win_line); end
        n_chk++; if (ain !== 9'h1C0 || bin !== 9'h011 || move_count !== 4'd5) begin n_fail++; $display("FAIL row_boards ain=%h bin=%h cnt=%0d exp 1c0 011 5", ain, bin, move_count); end
        tick();
        n_chk++; if (game_over !== 1'b1 || winner !== 2'b01 || move_ready !== 1'b0) begin n_fail++; $display("FAIL done_hold over=%b win=%b ready=%b exp 1 01 0", game_over, winner, move_ready); end
    endtask

    task automatic test_draw();
        start_game();
        n_chk++; if (ain !== 9'd0 || bin !== 9'd0 || winner !== 2'b00 || win_line !== 8'd0 || move_count !== 4'd0) begin n_fail++; $display("FAIL restart_clear ain=%h bin=%h win=%b line=%h cnt=%0d exp all 0", ain, bin, winner, win_line, move_count); end
        play(1'b0, 9'h010); play(1'b1, 9'h100); play(1'b0, 9'h004); play(1'b1, 9'h040);
        play(1'b0, 9'h080); play(1'b1, 9'h002); play(1'b0, 9'h008); play(1'b1, 9'h020);
        n_chk++; if (game_over !== 1'b0 || turn !== 1'b0 || move_count !== 4'd8) begin n_fail++; $display("FAIL pre_draw over=%b turn=%b cnt=%0d exp 0 0 8", game_over, turn, move_count); end
        play(1'b0, 9'h001);
        n_chk++; if (game_over !== 1'b1 || winner !== 2'b11 || win_line !== 8'h00) begin n_fail++; $display("FAIL draw over=%b win=%b line=%h exp 1 11 00", game_over, winner, win_line); end
        n_chk++; if (move_count !== 4'd9 || ain !== 9'h09D || bin !== 9'h162) begin n_fail++; $display("FAIL draw_boards cnt=%0d ain=%h bin=%h exp 9 09d 162", move_count, ain, bin); end
    endtask

    task automatic test_illegal();
        start_game();
        move_valid = 1'b1; move_player = 1'b1; move_pos = 9'h001;
        tick();
        n_chk++; if (illegal !== 1'b1 || ain !== 9'd0 || bin !== 9'd0 || move_ready !== 1'b1) begin n_fail++; $display("FAIL wrong_player illegal=%b ain=%h bin=%h ready=%b exp 1 0 0 1", illegal, ain, bin, move_ready); end
        tick();
        n_chk++; if (illegal !== 1'b1 || move_count !== 4'd0) begin n_fail++; $display("FAIL held_illegal illegal=%b cnt=%0d exp 1 0", illegal, move_count); end
        move_player = 1'b0; move_pos = 9'h003;
        tick();
        n_chk++; if (illegal !== 1'b1 || ain !== 9'd0) begin n_fail++; $display("FAIL two_hot illegal=%b ain=%h exp 1 000", illegal, ain); end
        move_pos = 9'h000;
        tick();
        n_chk++; if (illegal !== 1'b1 || ain !== 9'd0) begin n_fail++; $display("FAIL zero_pos illegal=%b ain=%h exp 1 000", illegal, ain); end
        move_valid = 1'b0;
        tick();
        n_chk++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL pulse_end illegal=%b exp 0", illegal); end
        move_valid = 1'b1; move_pos = 9'h001;
        tick();
        move_valid = 1'b0; move_pos = 9'd0;
        n_chk++; if (illegal !== 1'b0 || ain !== 9'h001 || move_count !== 4'd1) begin n_fail++; $display("FAIL legal_accept illegal=%b ain=%h cnt=%0d exp 0 001 1", illegal, ain, move_count); end
        tick();
        move_valid = 1'b1; move_player = 1'b1; move_pos = 9'h001;
        tick();
        move_valid = 1'b0; move_pos = 9'd0;
        n_chk++; if (illegal !== 1'b1 || bin !== 9'd0 || ain !== 9'h001 || turn !== 1'b1) begin n_fail++; $display("FAIL occupied illegal=%b bin=%h ain=%h turn=%b exp 1 000 001 1", illegal, bin, ain, turn); end
        tick();
    endtask

    task automatic test_diag_b();
        // game from previous test is still in TURN, so force back to IDLE first
        rst_n = 1'b0; #2; rst_n = 1'b1;
        tick();
        start_game();
        play(1'b0, 9'h100); play(1'b1, 9'h004); play(1'b0, 9'h080); play(1'b1, 9'h010); play(1'b0, 9'h001);
        move_valid = 1'b1; move_player = 1'b1; move_pos = 9'h040;
        tick();
        move_player = 1'b0; move_pos = 9'h002; start = 1'b1;
        tick();
        move_valid = 1'b0; move_pos = 9'd0; start = 1'b0;
        n_chk++; if (game_over !== 1'b1 || winner !== 2'b10 || win_line !== 8'h80 || illegal !== 1'b0) begin n_fail++; $display("FAIL diag_win over=%b win=%b line=%h illegal=%b exp 1 10 80 0", game_over, winner, win_line, illegal); end
        n_chk++; if (ain !== 9'h181 || bin !== 9'h054 || move_count !== 4'd6) begin n_fail++; $display("FAIL diag_boards ain=%h bin=%h cnt=%0d exp 181 054 6", ain, bin, move_count); end
        move_valid = 1'b1; move_player = 1'b0; move_pos = 9'h002;
        tick();
        move_valid = 1'b0; move_pos = 9'd0;
        n_chk++; if (illegal !== 1'b0 || ain !== 9'h181 || move_count !== 4'd6 || game_over !== 1'b1) begin n_fail++; $display("FAIL done_ignore illegal=%b ain=%h cnt=%0d over=%b exp 0 181 6 1", illegal, ain, move_count, game_over); end
    endtask

    task automatic test_reset_mid_check();
        start_game();
        move_valid = 1'b1; move_player = 1'b0; move_pos = 9'h010;
        tick();
        move_valid = 1'b0; move_pos = 9'd0;
        n_chk++; if (ain !== 9'h010 || move_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset ain=%h ready=%b exp 010 0", ain, move_ready); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (ain !== 9'd0 || bin !== 9'd0 || move_count !== 4'd0 || turn !== 1'b0 || winner !== 2'b00 || win_line !== 8'd0 || game_over !== 1'b0 || move_ready !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL async_reset ain=%h cnt=%0d turn=%b win=%b over=%b ready=%b exp all 0", ain, move_count, turn, winner, game_over, move_ready); end
        #1; rst_n = 1'b1;
        tick();
        n_chk++; if (move_ready !== 1'b0 || game_over !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle ready=%b over=%b exp 0 0", move_ready, game_over); end
        start_game();
        n_chk++; if (turn !== 1'b0 || ain !== 9'd0 || bin !== 9'd0 || move_ready !== 1'b1) begin n_fail++; $display("FAIL restart turn=%b ain=%h bin=%h ready=%b exp 0 000 000 1", turn, ain, bin, move_ready); end
    endtask

    task automatic test_timeout();
`ifdef MOVE_TIMEOUT_EN
        rst_n = 1'b0; #2; rst_n = 1'b1;
        tick();
        start_game();
        repeat (7) tick();
        n_chk++; if (game_over !== 1'b0 || move_ready !== 1'b1 || forfeit !== 1'b0) begin n_fail++; $display("FAIL pre_timeout over=%b ready=%b forf=%b exp 0 1 0", game_over, move_ready, forfeit); end
        tick();
        n_chk++; if (game_over !== 1'b1 || forfeit !== 1'b1 || winner !== 2'b10 || win_line !== 8'd0) begin n_fail++; $display("FAIL timeout over=%b forf=%b win=%b line=%h exp 1 1 10 00", game_over, forfeit, winner, win_line); end
        start_game();
        n_chk++; if (forfeit !== 1'b0 || winner !== 2'b00) begin n_fail++; $display("FAIL timeout_clear forf=%b win=%b exp 0 00", forfeit, winner); end
        repeat (7) tick();
        move_valid = 1'b1; move_player = 1'b0; move_pos = 9'h010;
        tick();
        move_valid = 1'b0; move_pos = 9'd0;
        n_chk++; if (game_over !== 1'b0 || forfeit !== 1'b0 || ain !== 9'h010 || move_count !== 4'd1) begin n_fail++; $display("FAIL last_cycle_move over=%b forf=%b ain=%h cnt=%0d exp 0 0 010 1", game_over, forfeit, ain, move_count); end
        tick();
        n_chk++; if (move_ready !== 1'b1 || turn !== 1'b1 || forfeit !== 1'b0) begin n_fail++; $display("FAIL after_last ready=%b turn=%b forf=%b exp 1 1 0", move_ready, turn, forfeit); end
`else
        repeat (20) tick();
        n_chk++; if (game_over !== 1'b0 || forfeit !== 1'b0 || move_ready !== 1'b1) begin n_fail++; $display("FAIL no_timeout over=%b forf=%b ready=%b exp 0 0 1", game_over, forfeit, move_ready); end
`endif
    endtask

    initial begin
        test_reset();
        test_row_win();
        test_draw();
        test_illegal();
        test_diag_b();
        test_reset_mid_check();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Sequences a two-player 3x3 game around the board-position registers `ain`/`bin`.
- Accepts moves through a valid/ready handshake and enforces turn order and legality.
- Evaluates three-in-a-row after every accepted move and declares a win, draw or forfeit.
- Sits between the player input front end and the display/scoring logic; owns the only copy of the board state.

Parameters:
- FIRST_PLAYER, 0, player that moves first after start (0 = A, 1 = B).
- TIMEOUT_CYCLES, 1000, cycles allowed per turn before forfeit (used only with MOVE_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin new game; honoured only in IDLE or DONE.
- move_valid  in  1  move request present.
- move_player  in  1  requesting player (0 = A, 1 = B).
- move_pos  in  9  one-hot square, bit 8 = top-left ... bit 0 = bottom-right.
- move_ready  out  1  controller can accept a move this cycle.
- illegal  out  1  one-cycle pulse: move presented but rejected.
- ain  out  9  squares held by A.
- bin  out  9  squares held by B.
- turn  out  1  player expected to move.
- move_count  out  4  accepted moves this game, 0..9.
- game_over  out  1  high in DONE.
- winner  out  2  00 none, 01 A, 10 B, 11 draw.
- win_line  out  8  one-hot winning line; all zero if none.
- forfeit  out  1  high in DONE when the game ended by timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0; `turn`=FIRST_PLAYER.
- States: IDLE, TURN, CHECK, DONE.
- IDLE: `move_ready`=0. On `start` -> TURN. Same edge clears `ain`, `bin`, `move_count`, `winner`, `win_line`, `forfeit`; `turn`=FIRST_PLAYER.
- TURN: `move_ready`=1. A move is accepted when `move_valid`=1 and all of the following hold:
  - `move_player`==`turn`;
  - `move_pos` is exactly one-hot;
  - `(move_pos & (ain|bin))`==0.
- On acceptance (same edge):
  - OR `move_pos` into the mover's board;
  - `move_count`+1;
  - -> CHECK.
- A rejected move with `move_valid`=1 gives `illegal`=1 for the following cycle only. State, boards and `move_count` are unchanged. A held invalid request pulses `illegal` every cycle.
- CHECK: `move_ready`=0, one cycle, evaluating the registered boards. Only the player who just moved is tested. Win lines:
  - bit0 = squares 8,7,6;
  - bit1 = 5,4,3;
  - bit2 = 2,1,0;
  - bit3 = 8,5,2;
  - bit4 = 7,4,1;
  - bit5 = 6,3,0;
  - bit6 = 8,4,0;
  - bit7 = 2,4,6.
  - If several lines complete at once, the lowest bit index wins (win_line stays one-hot).
- CHECK outcomes:
  - Win: `winner`=01/10, `win_line` latched -> DONE.
  - Else if `move_count`==9: `winner`=11, `win_line`=0 -> DONE.
  - Else: `turn` toggles -> TURN.
- Win/draw latency: 1 cycle after the acceptance edge.
- DONE: `game_over`=1. Outputs held until `start`, which restarts exactly as from IDLE.
- Simultaneous or ignored inputs:
  - `start` in TURN/CHECK is ignored.
  - `move_valid` outside TURN is ignored (no `illegal` pulse).
- Board invariant: `ain & bin`==0 at all times; `move_count` never exceeds 9.
- Reset mid-game: immediate return to IDLE values regardless of state.

Optional Feature:
- MOVE_TIMEOUT_EN defined:
  - a 16-bit cycle counter clears on entering TURN and increments each TURN cycle;
  - when it reaches TURN_CLYCLES-1 with no acceptance, next edge -> DONE with `forfeit`=1, `winner`= the opponent of `turn`, `win_line`=0;
  - an acceptance on that same edge takes priority over the timeout.
- Not defined: no counter, `forfeit` tied 0, TURN waits indefinitely.

Test Plan:
- Reset, start, then A:8, B:4, A:7, B:0, A:6 (A=player0 first) -> after the fifth acceptance + 1 cycle: `game_over`=1, `winner`=01, `win_line`=00000001, `ain`=1C0h, `bin`=011h, `move_count`=5.
- Full game A:4, B:8, A:2, B:6, A:7, B:1, A:3, B:5, A:0 -> `winner`=11, `win_line`=0, `move_count`=9.
- In TURN (A to move): B presents pos 0 -> `illegal` pulse, `ain`/`bin` unchanged. A presents 003h (two bits) -> `illegal`. Occupied square -> `illegal`. A presents 001h -> accepted.
- Diagonal win for B on 2,4,6 -> `winner`=10, `win_line`=80h; `move_valid`/`start` ignored while in CHECK.
- Assert rst_n=0 mid-CHECK -> all outputs 0 asynchronously; start after release -> `turn`=FIRST_PLAYER, boards empty.
- MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=8: start, idle 8 TURN cycles -> DONE, `forfeit`=1, `winner`=10. Repeat with the move on the final cycle -> accepted, no forfeit.

(Correction to the MOVE_TIMEOUT_EN threshold above: it is TIMEOUT_CYCLES-1.)
